axi_lite_instr_mem_slave: RTL and testbench
===========================================

// Module: axi_lite_instr_mem_slave
// PURPOSE
//  AXI-lite read-only subordinate serving the fetch stage's instruction requests (AR + R channels).
//  Holds an internal word-addressed instruction array and returns one 32-bit word per accepted address.
//  The read latency is configurable. A backdoor program port loads the array.
//  Sits between the core fetch unit (AR initiator) and the boot loader / testbench.
// PARAMETERS
//  ADDR_WIDTH    32     byte address width of AR channel
//  DATA_WIDTH    32     RDATA width (instruction word)
//  DEPTH_WORDS   1024   array depth in words; power of two
//  BASE_ADDR     0      byte address of word 0
//  READ_LATENCY  1      cycles from AR handshake to RVALID; legal 1..4
// PORTS
//  clk         in   1                 clock, all logic on posedge
//  rst         in   1                 synchronous reset, active-high
//  ARADDR      in   ADDR_WIDTH        read address (byte)
//  ARVALID     in   1                 address valid
//  ARREADY     out  1                 address accepted when ARVALID&ARREADY
//  RDATA       out  DATA_WIDTH        read data
//  RRESP       out  2                 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR
//  RVALID      out  1                 response valid
//  RREADY      in   1                 response accepted when RVALID&RREADY
//  prog_we     in   1                 backdoor write enable
//  prog_addr   in   $clog2(DEPTH_WORDS) backdoor word index
//  prog_wdata  in   DATA_WIDTH        backdoor write data
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, ARREADY=0, RVALID=0, RDATA=0, RRESP=0, latency counter=0.
//   - ARREADY is a register: 1 from the first cycle after rst deasserts. Array contents are not reset.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: ARREADY=1. On ARVALID&ARREADY at edge T:
//     - latch the response word (array read at T) and RRESP;
//     - ARREADY->0; cnt=READ_LATENCY-1.
//     - Goes to RESP if READ_LATENCY==1, else WAIT.
//   - WAIT: decrement cnt each cycle; go to RESP when cnt reaches 1.
//   - RESP: RVALID=1 with RDATA/RRESP stable until RVALID&RREADY. Then RVALID->0, ARREADY->1, back to IDLE.
//  Latency: AR handshake at edge T -> RVALID high in cycle after edge T+READ_LATENCY-1.
//   - Exactly READ_LATENCY cycles after the handshake cycle.
//  Throughput: one outstanding transaction; with RREADY=1, at most one read per READ_LATENCY+1 cycles.
//  Index = (ARADDR-BASE_ADDR)>>2, DEPTH_WORDS-wide. Subtraction is modulo 2^ADDR_WIDTH.
//  Decode error: ARADDR<BASE_ADDR or ARADDR>=BASE_ADDR+4*DEPTH_WORDS -> RRESP=2'b11, RDATA=0.
//  ARVALID low or deasserted while ARREADY=0: ignored, no state change.
//  prog_we: write at posedge, any state. Same word as a same-edge AR handshake -> response holds OLD word.
//   - A prog write after the handshake never alters the latched RDATA.
//  RREADY held low: RESP held indefinitely, no new AR accepted (ARREADY=0).
//  rst mid-transaction (WAIT or RESP): transaction dropped; next cycle RVALID=0, IDLE per reset rules.
// CONFIGURATION
//  MISALIGN_ERR_EN defined: ARADDR[1:0]!=0 (in-range) -> RRESP=2'b10, RDATA=0. Decode error has priority.
//  MISALIGN_ERR_EN undefined: ARADDR[1:0] ignored; word at ARADDR&~3 returned with OKAY.
// TESTING
//  T1 Reset: hold rst=1 3 cycles, ARVALID=1.
//   -> ARREADY=0 and RVALID=0 during reset.
//   -> ARREADY=1 first cycle after release; first handshake only then.
//  T2 Basic read, READ_LATENCY=1, RREADY=1: prog word 2=32'h00500093, AR 32'h8.
//   -> RVALID 1 cycle later, RDATA=32'h00500093, RRESP=00.
//   -> ARREADY back high the following cycle.
//  T3 Backpressure, READ_LATENCY=3: AR 32'h0, RREADY=0 for 5 cycles.
//   -> RVALID rises 3 cycles after handshake; RDATA stable; ARREADY=0 throughout.
//   -> Completes on the RREADY=1 edge.
//  T4 Decode error, DEPTH_WORDS=1024, BASE_ADDR=0: AR 32'h1000 -> RRESP=11, RDATA=0.
//   -> Next AR 32'hFFC returns word 1023 with OKAY.
//  T5 Collision: word 4=A, same edge as AR 32'h10 handshake prog_we writes B to word 4.
//   -> RDATA=A; next read of 32'h10 returns B.
//  T6 Misalign / mid-reset: AR 32'h6.
//   -> SLVERR with MISALIGN_ERR_EN; word 1 OKAY without it.
//   -> rst=1 during WAIT -> RVALID never asserted for that request; IDLE after release.

Source files
------------

// File: rtl/axi_lite_instr_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_instr_mem_slave
// Description : Read-only AXI-lite subordinate (AR + R channels) that serves
//               instruction fetches from an internal word-addressed array.
//               A backdoor program port loads the array. Each accepted
//               address returns one DATA_WIDTH word after READ_LATENCY
//               cycles. Only one transaction can be outstanding at a time.
// Config      : define MISALIGN_ERR_EN to return SLVERR for in-range
//               addresses with ARADDR[1:0] != 0. Without it, the low address
//               bits are ignored.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               ARADDR/ARVALID/ARREADY   - read address channel
//               RDATA/RRESP/RVALID/RREADY- read data channel
//               prog_we/prog_addr/prog_wdata - backdoor array write port
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_instr_mem_slave #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0]          prog_wdata
);

  localparam int                  c_IDX_W    = $clog2(DEPTH_WORDS);
  // Span of the array in bytes, one bit wider than the address so that a
  // full-size array cannot overflow the comparison.
  localparam logic [ADDR_WIDTH:0] c_SPAN     = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
  localparam logic [2:0]          c_CNT_INIT = 3'(READ_LATENCY - 1);
  localparam bit                  c_DIRECT   = (READ_LATENCY == 1);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state,   w_state_nxt;
  logic                    r_arready, w_arready_nxt;
  logic                    r_rvalid,  w_rvalid_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata,   w_rdata_nxt;
  logic [1:0]              r_rresp,   w_rresp_nxt;
  logic [2:0]              r_cnt,     w_cnt_nxt;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_in_range;
  logic [c_IDX_W-1:0]      w_idx;
  logic                    w_ar_hs;
  logic [DATA_WIDTH-1:0]   w_hs_data;
  logic [1:0]              w_hs_resp;

  // Offset wraps modulo 2^ADDR_WIDTH; the explicit lower-bound test catches
  // addresses below BASE_ADDR that would otherwise wrap into range.
  assign w_offset   = ARADDR - BASE_ADDR;
  assign w_in_range = (ARADDR >= BASE_ADDR) && ({1'b0, w_offset} < c_SPAN);
  assign w_idx      = w_offset[c_IDX_W+1:2];
  assign w_ar_hs    = ARVALID & r_arready;

  // Response word as it would be captured at this edge. The array read sees
  // the pre-edge contents, so a same-edge backdoor write yields the old word.
  always_comb begin
    w_hs_data = r_mem[w_idx];
    w_hs_resp = c_RESP_OKAY;
    if (!w_in_range) begin
      w_hs_data = '0;
      w_hs_resp = c_RESP_DECERR;
    end
`ifdef MISALIGN_ERR_EN
    else if (ARADDR[1:0] != 2'b00) begin
      w_hs_data = '0;
      w_hs_resp = c_RESP_SLVERR;
    end
`endif
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_ar_hs) begin
          w_rdata_nxt   = w_hs_data;
          w_rresp_nxt   = w_hs_resp;
          w_arready_nxt = 1'b0;
          w_cnt_nxt     = c_CNT_INIT;
          if (c_DIRECT) begin
            w_state_nxt  = ST_RESP;
            w_rvalid_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Counter holds the remaining cycles; RVALID rises on the edge where
        // it would reach zero so the total latency equals READ_LATENCY.
        if (r_cnt <= 3'd1) begin
          w_state_nxt  = ST_RESP;
          w_rvalid_nxt = 1'b1;
          w_cnt_nxt    = 3'd0;
        end else begin
          w_cnt_nxt    = r_cnt - 3'd1;
        end
      end
      ST_RESP: begin
        w_rvalid_nxt = 1'b1;
        if (RREADY) begin
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_cnt     <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Array contents survive reset so a program loaded before reset release
  // is still valid afterwards.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_wdata;
    end
  end

  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_instr_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_instr_mem_slave
// Description : Directed self-checking bench. Two instances share clk, rst
//               and the program port: u_dut1 with READ_LATENCY=1 and
//               u_dut3 with READ_LATENCY=3. Inputs change and outputs are
//               sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_instr_mem_slave;

  localparam logic [31:0] c_W0    = 32'hCAFE_F00D;
  localparam logic [31:0] c_W1    = 32'h1111_1111;
  localparam logic [31:0] c_W2    = 32'h0050_0093;
  localparam logic [31:0] c_WA    = 32'hAAAA_0004;
  localparam logic [31:0] c_WB    = 32'hBBBB_0004;
  localparam logic [31:0] c_W1023 = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_wdata;

  logic [31:0] araddr1, rdata1, araddr3, rdata3;
  logic        arvalid1, arready1, rvalid1, rready1;
  logic        arvalid3, arready3, rvalid3, rready3;
  logic [1:0]  rresp1, rresp3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_instr_mem_slave #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ARADDR(araddr1), .ARVALID(arvalid1), .ARREADY(arready1),
    .RDATA(rdata1), .RRESP(rresp1), .RVALID(rvalid1), .RREADY(rready1),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  axi_lite_instr_mem_slave #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .ARADDR(araddr3), .ARVALID(arvalid3), .ARREADY(arready3),
    .RDATA(rdata3), .RRESP(rresp3), .RVALID(rvalid3), .RREADY(rready3),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [9:0] a, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  // Single read on the latency-1 instance with RREADY held high.
  task automatic rd1(input string tag, input logic [31:0] a,
                     input logic [31:0] exp_d, input logic [1:0] exp_r);
    araddr1  = a;
    arvalid1 = 1'b1;
    @(negedge clk);
    arvalid1 = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid1), 32'd1);
    chk({tag, "_rdata"},  rdata1,       exp_d);
    chk({tag, "_rresp"},  32'(rresp1),  32'(exp_r));
    @(negedge clk);
    chk({tag, "_arready_back"}, 32'(arready1), 32'd1);
    chk({tag, "_rvalid_drop"},  32'(rvalid1),  32'd0);
  endtask

  initial begin
    logic [31:0] exp_mis_d;
    logic [1:0]  exp_mis_r;
    int          lat;
`ifdef MISALIGN_ERR_EN
    exp_mis_d = 32'h0;
    exp_mis_r = 2'b10;
`else
    exp_mis_d = c_W1;
    exp_mis_r = 2'b00;
`endif
    rst = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    araddr1 = 32'h8; arvalid1 = 1'b1; rready1 = 1'b0;
    araddr3 = 32'h0; arvalid3 = 1'b0; rready3 = 1'b0;

    // Load the program while reset is asserted; the array is not reset.
    @(negedge clk);
    prog(10'd0,    c_W0);
    prog(10'd1,    c_W1);
    prog(10'd2,    c_W2);
    prog(10'd4,    c_WA);
    prog(10'd1023, c_W1023);

    // T1: three reset cycles with ARVALID high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_arready", 32'(arready1), 32'd0);
      chk("rst_rvalid",  32'(rvalid1),  32'd0);
    end
    chk("rst_rdata", rdata1,      32'd0);
    chk("rst_rresp", 32'(rresp1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_arready", 32'(arready1), 32'd1);
    chk("rel_rvalid",  32'(rvalid1),  32'd0);

    // T2: the pending AR of 0x8 is accepted now.
    rready1 = 1'b1;
    rready3 = 1'b0;
    @(negedge clk);
    arvalid1 = 1'b0;
    chk("t2_rvalid",  32'(rvalid1),  32'd1);
    chk("t2_rdata",   rdata1,        c_W2);
    chk("t2_rresp",   32'(rresp1),   32'd0);
    chk("t2_arready", 32'(arready1), 32'd0);
    @(negedge clk);
    chk("t2_arready_back", 32'(arready1), 32'd1);
    chk("t2_rvalid_drop",  32'(rvalid1),  32'd0);

    // T3: latency 3 with backpressure.
    chk("t3_arready_idle", 32'(arready3), 32'd1);
    araddr3 = 32'h0;
    arvalid3 = 1'b1;
    @(negedge clk);
    arvalid3 = 1'b0;
    chk("t3_c1_rvalid",  32'(rvalid3),  32'd0);
    chk("t3_c1_arready", 32'(arready3), 32'd0);
    @(negedge clk);
    chk("t3_c2_rvalid",  32'(rvalid3),  32'd0);
    @(negedge clk);
    chk("t3_c3_rvalid",  32'(rvalid3),  32'd1);
    chk("t3_c3_rdata",   rdata3,        c_W0);
    chk("t3_c3_rresp",   32'(rresp3),   32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_rvalid",  32'(rvalid3),  32'd1);
      chk("t3_hold_rdata",   rdata3,        c_W0);
      chk("t3_hold_arready", 32'(arready3), 32'd0);
    end
    rready3 = 1'b1;
    @(negedge clk);
    chk("t3_done_rvalid",  32'(rvalid3),  32'd0);
    chk("t3_done_arready", 32'(arready3), 32'd1);

    // T4: decode error just past the array, then the last valid word.
    rd1("t4_decerr", 32'h1000, 32'h0, 2'b11);
    rd1("t4_last",   32'hFFC,  c_W1023, 2'b00);
    rd1("t4_high",   32'hFFFF_FFFC, 32'h0, 2'b11);

    // T5: backdoor write to word 4 on the same edge as the handshake.
    araddr1 = 32'h10;
    arvalid1 = 1'b1;
    prog_we = 1'b1; prog_addr = 10'd4; prog_wdata = c_WB;
    @(negedge clk);
    prog_we = 1'b0;
    arvalid1 = 1'b0;
    chk("t5_rvalid", 32'(rvalid1), 32'd1);
    chk("t5_old",    rdata1,       c_WA);
    @(negedge clk);
    rd1("t5_new", 32'h10, c_WB, 2'b00);

    // T6: misaligned address, then reset during WAIT on the latency-3 part.
    rd1("t6_mis", 32'h6, exp_mis_d, exp_mis_r);
    araddr3 = 32'h6;
    arvalid3 = 1'b1;
    @(negedge clk);
    arvalid3 = 1'b0;
    chk("t6_wait_rvalid", 32'(rvalid3), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_rvalid",  32'(rvalid3),  32'd0);
    chk("t6_rst_arready", 32'(arready3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_post_rvalid",  32'(rvalid3),  32'd0);
      chk("t6_post_arready", 32'(arready3), 32'd1);
    end

    // Fresh read after recovery: RVALID must appear exactly 3 cycles later.
    araddr3 = 32'h8;
    arvalid3 = 1'b1;
    @(negedge clk);
    arvalid3 = 1'b0;
    lat = 1;
    while (rvalid3 !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_recover_latency", 32'(lat), 32'd3);
    chk("t6_recover_rdata",   rdata3,   c_W2);
    chk("t6_recover_rresp",   32'(rresp3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
